// File: rtl/ssp_pkg.sv
// ----------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the synchronous serial port receive path.
//   - SSP_DATA_W_DEF      : default serial word width
//   - SSP_SYNC_STAGES_DEF : default synchronizer depth (must be >= 2)
//   - ssp_state_e         : receive FSM states (IDLE, SHIFT)
// ----------------------------------------------------------------------------
package ssp_pkg;

    localparam int SSP_DATA_W_DEF      = 8;
    localparam int SSP_SYNC_STAGES_DEF = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ssp_state_e;

endpackage : ssp_pkg

// File: rtl/ssp_sync_edge.sv
// ----------------------------------------------------------------------------
// ssp_sync_edge
// Multi-flop synchronizer for one asynchronous serial input, plus a
// previous-value flop for rising-edge detection in the PCLK domain.
// Ports:
//   clk_i    in  1  PCLK
//   rst_ni   in  1  synchronous active-low reset (clears all flops)
//   async_i  in  1  asynchronous input
//   level_o  out 1  synchronized level
//   rise_o   out 1  one-cycle pulse: synced level high, previous synced value low
// ----------------------------------------------------------------------------
module ssp_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain and previous-value flop; all cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : ssp_sync_edge

// File: rtl/ssp_rx_deserializer.sv
// ----------------------------------------------------------------------------
// ssp_rx_deserializer
// Receive front end of the synchronous serial port (PCLK domain).
// Oversamples SSPCLKIN/SSPFSSIN/SSPRXD through equal-depth synchronizers,
// frames DATA_W-bit words (MSB first) after a one-bit-period FSS pulse and
// presents each completed word on RxData with a one-cycle rx_ready strobe.
//
// Ports:
//   PCLK       in  1       system clock (rising edge)
//   CLEAR_B    in  1       synchronous active-low reset
//   SSPCLKIN   in  1       serial bit clock (asynchronous)
//   SSPFSSIN   in  1       frame sync, high during the bit before the MSB
//   SSPRXD     in  1       serial receive data
//   rx_full    in  1       downstream FIFO full
//   RxData     out DATA_W  last completed word, held until the next one
//   rx_ready   out 1       one-cycle strobe, RxData new and valid
//   rx_overrun out 1       sticky overrun flag
//
// Build option:
//   SSP_RX_OVERRUN_EN  when defined, a word completing while rx_full=1 sets
//                      rx_overrun (sticky until CLEAR_B). When undefined,
//                      rx_overrun is tied to 0.
// ----------------------------------------------------------------------------
module ssp_rx_deserializer
    import ssp_pkg::*;
#(
    parameter int DATA_W      = SSP_DATA_W_DEF,
    parameter int SYNC_STAGES = SSP_SYNC_STAGES_DEF
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
    input  logic              rx_full,
    output logic [DATA_W-1:0] RxData,
    output logic              rx_ready,
    output logic              rx_overrun
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchronized inputs
    logic sclk_lvl_s, rise_s;
    logic fss_s, fss_rise_s;
    logic rxd_s, rxd_rise_s;

    // FSM and datapath state
    ssp_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_ready_q, rx_ready_d;

    // FSM control outputs
    logic              last_bit_s;
    logic              shift_en_s;
    logic              cnt_clr_s;
    logic              cnt_inc_s;
    logic              word_done_s;
    logic [DATA_W-1:0] word_s;

    ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk_i   (PCLK),
        .rst_ni  (CLEAR_B),
        .async_i (SSPCLKIN),
        .level_o (sclk_lvl_s),
        .rise_o  (rise_s)
    );

    ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fss (
        .clk_i   (PCLK),
        .rst_ni  (CLEAR_B),
        .async_i (SSPFSSIN),
        .level_o (fss_s),
        .rise_o  (fss_rise_s)
    );

    ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rxd (
        .clk_i   (PCLK),
        .rst_ni  (CLEAR_B),
        .async_i (SSPRXD),
        .level_o (rxd_s),
        .rise_o  (rxd_rise_s)
    );

    assign last_bit_s = (cnt_q == CNT_LAST);
    // Word as it will look once the current RXD bit is shifted in.
    assign word_s     = {shift_q[DATA_W-2:0], rxd_s};

    // FSM state register.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave IDLE on FSS, leave SHIFT only on a last bit without FSS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s && fss_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (rise_s && last_bit_s && !fss_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: datapath controls decided on each synced SSPCLKIN rise.
    always_comb begin
        shift_en_s  = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        word_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_s && fss_s) begin
                    cnt_clr_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (rise_s) begin
                    if (fss_s && !last_bit_s) begin
                        // Frame error: drop partial word, restart without shifting.
                        cnt_clr_s = 1'b1;
                    end else if (last_bit_s) begin
                        // Last bit completes the word even when FSS is also high.
                        shift_en_s  = 1'b1;
                        word_done_s = 1'b1;
                        cnt_clr_s   = 1'b1;
                    end else begin
                        shift_en_s = 1'b1;
                        cnt_inc_s  = 1'b1;
                    end
                end else begin
                    shift_en_s = 1'b0;
                end
            end
            default: begin
                shift_en_s  = 1'b0;
                cnt_clr_s   = 1'b0;
                cnt_inc_s   = 1'b0;
                word_done_s = 1'b0;
            end
        endcase
    end

    // Datapath next state: bit counter, shift register and output registers.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = 1'b0;
        if (cnt_clr_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (shift_en_s) begin
            shift_d = word_s;
        end else begin
            shift_d = shift_q;
        end
        if (word_done_s) begin
            rx_data_d  = word_s;
            rx_ready_d = 1'b1;
        end else begin
            rx_data_d  = rx_data_q;
            rx_ready_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            cnt_q      <= {CNT_W{1'b0}};
            shift_q    <= {DATA_W{1'b0}};
            rx_data_q  <= {DATA_W{1'b0}};
            rx_ready_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign RxData   = rx_data_q;
    assign rx_ready = rx_ready_q;

`ifdef SSP_RX_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Overrun next state: set when a word completes into a full FIFO, then sticky.
    always_comb begin
        if (word_done_s && rx_full) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Overrun register.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign rx_overrun = overrun_q;

    logic unused_ok_s;
    assign unused_ok_s = ^{sclk_lvl_s, fss_rise_s, rxd_rise_s};
`else
    assign rx_overrun = 1'b0;

    logic unused_ok_s;
    assign unused_ok_s = ^{sclk_lvl_s, fss_rise_s, rxd_rise_s, rx_full};
`endif

endmodule : ssp_rx_deserializer

// File: tb/tb_ssp_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_ssp_rx_deserializer
// Self-checking bench: table of framed bit sequences, hand-written corner
// sequences (strobe latency, reset mid-frame, idle noise, overrun) and
// randomized bit streams compared with a queue-based frame model.
// ----------------------------------------------------------------------------
module tb_ssp_rx_deserializer;

    logic       PCLK = 1'b0;
    logic       CLEAR_B = 1'b0;
    logic       SSPCLKIN = 1'b0;
    logic       SSPFSSIN = 1'b0;
    logic       SSPRXD = 1'b0;
    logic       rx_full = 1'b0;
    logic [7:0] RxData;
    logic       rx_ready;
    logic       rx_overrun;

`ifdef SSP_RX_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    localparam longint BIT_T = 80;   // 8 PCLK periods of 10 per serial bit

    int tests  = 0;
    int failed = 0;

    logic [7:0] got_q[$];
    longint     strobe_t[$];
    logic       prev_ready = 1'b0;
    logic       ovr_at_strobe = 1'b0;

    logic       fss_q[$];
    logic       rxd_q[$];
    logic [7:0] exp_q[$];

    ssp_rx_deserializer dut (
        .PCLK       (PCLK),
        .CLEAR_B    (CLEAR_B),
        .SSPCLKIN   (SSPCLKIN),
        .SSPFSSIN   (SSPFSSIN),
        .SSPRXD     (SSPRXD),
        .rx_full    (rx_full),
        .RxData     (RxData),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun)
    );

    always #5 PCLK = ~PCLK;

    // Monitor: capture every strobe and check it lasts a single cycle.
    always @(negedge PCLK) begin
        if (rx_ready) begin
            got_q.push_back(RxData);
            strobe_t.push_back($time);
            ovr_at_strobe = rx_overrun;
            tests++;
            if (prev_ready) begin
                failed++;
                $display("FAIL strobe_width: rx_ready high on consecutive cycles at t=%0t, required single cycle", $time);
            end
        end
        prev_ready = rx_ready;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic send_bit(input logic f, input logic d);
        SSPFSSIN = f;
        SSPRXD   = d;
        SSPCLKIN = 1'b0;
        tick(4);
        SSPCLKIN = 1'b1;
        tick(4);
    endtask

    task automatic send_frame(input logic [7:0] w);
        send_bit(1'b1, 1'b0);
        for (int k = 7; k >= 0; k--) send_bit(1'b0, w[k]);
    endtask

    task automatic do_reset();
        SSPCLKIN = 1'b0;
        SSPFSSIN = 1'b0;
        SSPRXD   = 1'b0;
        CLEAR_B  = 1'b0;
        tick(2);
        CLEAR_B  = 1'b1;
        tick(1);
        got_q.delete();
        strobe_t.delete();
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] w, input int pos);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < 8; k++) r[pos + k] = w[7 - k];
        return r;
    endfunction

    // Frame model: an FSS bit opens a frame; the next 8 bits form a word.
    // FSS before the 8th bit restarts the frame; FSS on the 8th bit opens the next one.
    function automatic void run_model();
        int  cur[$];
        bit  in_frame;
        int  val;
        in_frame = 1'b0;
        exp_q.delete();
        for (int i = 0; i < fss_q.size(); i++) begin
            if (in_frame && cur.size() == 7) begin
                cur.push_back(int'(rxd_q[i]));
                val = 0;
                foreach (cur[j]) val = val * 2 + cur[j];
                exp_q.push_back(val[7:0]);
                cur.delete();
                in_frame = fss_q[i];
            end else if (fss_q[i]) begin
                in_frame = 1'b1;
                cur.delete();
            end else if (in_frame) begin
                cur.push_back(int'(rxd_q[i]));
            end
        end
    endfunction

    typedef struct {
        int          nbits;
        logic [31:0] fss_v;
        logic [31:0] rxd_v;
        int          exp_cnt;
        logic [7:0]  exp_word;
        longint      exp_gap;
    } vec_t;

    vec_t tbl[5];
    logic pat[5];
    logic [7:0] data_at_strobe;

    initial begin
        tbl[0] = '{9,  32'h1,   word_at(8'hA5, 1),                     1, 8'hA5, 0};
        tbl[1] = '{17, 32'h101, word_at(8'h3C, 1) | word_at(8'h3C, 9), 2, 8'h3C, 8 * BIT_T};
        tbl[2] = '{14, 32'h21,  32'h1E | word_at(8'hF0, 6),            1, 8'hF0, 0};
        tbl[3] = '{9,  32'h1,   word_at(8'h00, 1),                     1, 8'h00, 0};
        tbl[4] = '{9,  32'h1,   word_at(8'hFF, 1),                     1, 8'hFF, 0};

        // Reset state
        SSPCLKIN = 1'b0;
        CLEAR_B  = 1'b0;
        tick(3);
        check("reset_rxdata", 32'(RxData), 32'h0);
        check("reset_ready", 32'(rx_ready), 32'h0);
        check("reset_overrun", 32'(rx_overrun), 32'h0);
        CLEAR_B = 1'b1;
        tick(1);

        // Table vectors
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < tbl[v].nbits; i++) send_bit(tbl[v].fss_v[i], tbl[v].rxd_v[i]);
            send_bit(1'b0, 1'b0);
            send_bit(1'b0, 1'b0);
            tick(4);
            check($sformatf("vec%0d_strobes", v), 32'(got_q.size()), 32'(tbl[v].exp_cnt));
            check($sformatf("vec%0d_rxdata", v), 32'(RxData), 32'(tbl[v].exp_word));
            if (tbl[v].exp_gap != 0 && strobe_t.size() >= 2) begin
                check($sformatf("vec%0d_gap", v), 32'(strobe_t[1] - strobe_t[0]), 32'(tbl[v].exp_gap));
            end
        end

        // Strobe latency: rx_ready high on the 3rd edge after the last rise is first sampled
        do_reset();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
        SSPFSSIN = 1'b0;
        SSPRXD   = 1'b1;
        SSPCLKIN = 1'b0;
        tick(4);
        SSPCLKIN = 1'b1;
        data_at_strobe = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            pat[k] = rx_ready;
            if (rx_ready) data_at_strobe = RxData;
        end
        tick(1);
        check("latency_pattern", {27'h0, pat[0], pat[1], pat[2], pat[3], pat[4]}, 32'b00100);
        check("latency_data", 32'(data_at_strobe), 32'hA5);

        // Reset mid-frame
        do_reset();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        CLEAR_B = 1'b0;
        tick(1);
        CLEAR_B = 1'b1;
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1);
        tick(4);
        check("midreset_strobes", 32'(got_q.size()), 32'h0);
        check("midreset_rxdata", 32'(RxData), 32'h0);
        send_frame(8'h81);
        send_bit(1'b0, 1'b0);
        tick(4);
        check("after_reset_strobes", 32'(got_q.size()), 32'h1);
        check("after_reset_rxdata", 32'(RxData), 32'h81);

        // Idle noise
        do_reset();
        for (int i = 0; i < 20; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
        tick(4);
        check("idle_strobes", 32'(got_q.size()), 32'h0);
        check("idle_rxdata", 32'(RxData), 32'h0);

        // Overrun
        do_reset();
        check("ovr_initial", 32'(rx_overrun), 32'h0);
        rx_full = 1'b1;
        send_frame(8'h55);
        send_bit(1'b0, 1'b0);
        tick(4);
        rx_full = 1'b0;
        check("ovr_strobes", 32'(got_q.size()), 32'h1);
        check("ovr_rxdata", 32'(RxData), 32'h55);
        check("ovr_with_strobe", 32'(ovr_at_strobe), 32'(EXP_OVR));
        send_frame(8'hAA);
        send_bit(1'b0, 1'b0);
        tick(4);
        check("ovr_sticky", 32'(rx_overrun), 32'(EXP_OVR));
        check("ovr_next_word", 32'(RxData), 32'hAA);
        do_reset();
        check("ovr_cleared", 32'(rx_overrun), 32'h0);

        // Randomized streams against the frame model
        for (int s = 0; s < 6; s++) begin
            logic [7:0] w;
            fss_q.delete();
            rxd_q.delete();
            for (int n = 0; n < 10; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    fss_q.push_back($urandom_range(0, 4) == 0);
                    rxd_q.push_back(1'($urandom_range(0, 1)));
                end else begin
                    w = 8'($urandom);
                    fss_q.push_back(1'b1);
                    rxd_q.push_back(1'($urandom_range(0, 1)));
                    for (int k = 7; k >= 0; k--) begin
                        if (k == 0) fss_q.push_back($urandom_range(0, 1) == 1);
                        else        fss_q.push_back($urandom_range(0, 15) == 0);
                        rxd_q.push_back(w[k]);
                    end
                end
            end
            for (int k = 0; k < 9; k++) begin
                fss_q.push_back(1'b0);
                rxd_q.push_back(1'($urandom_range(0, 1)));
            end
            run_model();
            do_reset();
            for (int i = 0; i < fss_q.size(); i++) send_bit(fss_q[i], rxd_q[i]);
            tick(4);
            check($sformatf("rand%0d_count", s), 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                check($sformatf("rand%0d_word%0d", s, i), 32'(got_q[i]), 32'(exp_q[i]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_ssp_rx_deserializer
